// File: rtl/rr_mux_arbiter_4ch.sv
// Round-robin 4:1 arbiter/sequencer: grants one requester at a time, drives the
// mux select and forwards the selected word downstream over valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant outstanding; arbitrate from ptr on any request
// GRANT   | sel_q owns the datapath until it drops or hits MAX_HOLD
module rr_mux_arbiter_4ch #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [3:0]         req_in,
  input  logic [4*WIDTH-1:0] data_in,
  input  logic               ready_in,
  output logic [3:0]         gnt_out,
  output logic [1:0]         sel_out,
  output logic               valid_out,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy_out
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic             xfer;
  logic             rel;
  logic [WIDTH-1:0] ch_data [4];

  // Lowest offset from ptr wins, so scan offsets high-to-low and let the last hit stand.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] s);
    one_hot = 4'b0001 << s;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_data[i] = data_in[i*WIDTH +: WIDTH];
    end
  end

  assign valid_out = (state_q == ST_GRANT) && req_in[sel_q];
  assign data_out  = ch_data[sel_q];
  assign busy_out  = (state_q == ST_GRANT);
  assign gnt_out   = gnt_q;
  assign sel_out   = sel_q;

  assign xfer = valid_out && ready_in;
  assign rel  = (state_q == ST_GRANT) &&
                (!req_in[sel_q] || (xfer && (cnt_q == CNT_LAST)));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (|req_in) begin
        sel_d   = rr_pick(ptr_q, req_in);
        gnt_d   = one_hot(sel_d);
        cnt_d   = 8'd0;
        state_d = ST_GRANT;
      end else begin
        gnt_d = 4'b0000;
      end
    end else begin
      if (rel) begin
        ptr_d = sel_q + 2'd1;
        // A dropped requester is already zero in req_in; at the limit it stays
        // eligible, so a lone requester wraps back to itself.
        if (|req_in) begin
          sel_d = rr_pick(sel_q + 2'd1, req_in);
          gnt_d = one_hot(sel_d);
          cnt_d = 8'd0;
        end else begin
          gnt_d   = 4'b0000;
          state_d = ST_IDLE;
        end
      end else if (xfer) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4ch.sv
// Scoreboard bench for rr_mux_arbiter_4ch: directed scenarios then random traffic,
// expected outputs from a transfer-counting reference model.
module tb_rr_mux_arbiter_4ch;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 8;

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic [3:0]         req_in;
  logic [4*WIDTH-1:0] data_in;
  logic               ready_in;
  logic [3:0]         gnt_out;
  logic [1:0]         sel_out;
  logic               valid_out;
  logic [WIDTH-1:0]   data_out;
  logic               busy_out;

  always #5 clk_in = ~clk_in;

  rr_mux_arbiter_4ch #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .data_in(data_in),
    .ready_in(ready_in), .gnt_out(gnt_out), .sel_out(sel_out), .valid_out(valid_out),
    .data_out(data_out), .busy_out(busy_out)
  );

  typedef struct {
    int               cyc;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: who owns the datapath, how many words it has moved, and
  // where the next search starts.
  bit m_busy = 0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_done = 0;

  function automatic int rr_win(int p, logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_done = 0;
  endtask

  task automatic model_edge(logic [3:0] r, logic rdy);
    bit moved, rel;
    if (!m_busy) begin
      if (r != 4'b0) begin
        m_sel = rr_win(m_ptr, r); m_busy = 1; m_done = 0;
      end
    end else begin
      moved = r[m_sel] && rdy;
      rel   = !r[m_sel] || (moved && (m_done + 1 == MAX_HOLD));
      if (rel) begin
        m_ptr = (m_sel + 1) % 4;
        if (r != 4'b0) begin
          m_sel = rr_win(m_ptr, r); m_done = 0;
        end else begin
          m_busy = 0;
        end
      end else if (moved) begin
        m_done++;
      end
    end
  endtask

  task automatic drive_cycle(logic [3:0] r, logic rdy, logic rst, logic [31:0] d);
    exp_t e;
    @(negedge clk_in);
    #1;
    req_in = r; ready_in = rdy; rst_n_in = rst; data_in = d;
    #1;
    if (!rst) model_reset();
    e.cyc   = cyc;
    e.gnt   = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.busy  = m_busy;
    e.valid = m_busy && r[m_sel];
    e.data  = d[m_sel*WIDTH +: WIDTH];
    sb_q.push_back(e);
    if (rst) model_edge(r, rdy);
    cyc++;
  endtask

  task automatic chk(string name, int c, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("gnt_out",   e.cyc, 32'(gnt_out),   32'(e.gnt));
        chk("sel_out",   e.cyc, 32'(sel_out),   32'(e.sel));
        chk("busy_out",  e.cyc, 32'(busy_out),  32'(e.busy));
        chk("valid_out", e.cyc, 32'(valid_out), 32'(e.valid));
        if (e.valid) chk("data_out", e.cyc, 32'(data_out), 32'(e.data));
      end
    end
  end

  function automatic logic [31:0] rnd();
    return $urandom();
  endfunction

  logic [3:0] rq;

  initial begin : stim
    rst_n_in = 1'b0; req_in = 4'b0; ready_in = 1'b0; data_in = '0;
    drive_cycle(4'b0000, 1'b0, 1'b0, rnd());
    drive_cycle(4'b0000, 1'b0, 1'b1, rnd());

    // Single requester on channel 2 with a fixed word, two full bursts.
    for (int i = 0; i < 18; i++) drive_cycle(4'b0100, 1'b1, 1'b1, 32'h00A5_0000 | (rnd() & 32'hFF00_FFFF));

    // All requesting: full rotation plus wrap to channel 0.
    drive_cycle(4'b0000, 1'b0, 1'b0, rnd());
    for (int i = 0; i < 42; i++) drive_cycle(4'b1111, 1'b1, 1'b1, rnd());

    // Channel 0 drops after 3 transfers; channel 1 takes over with no bubble.
    drive_cycle(4'b0000, 1'b0, 1'b0, rnd());
    for (int i = 0; i < 4; i++) drive_cycle(4'b0011, 1'b1, 1'b1, rnd());
    for (int i = 0; i < 4; i++) drive_cycle(4'b0010, 1'b1, 1'b1, rnd());

    // Channel 1 burst stalled for 5 cycles, then completes.
    drive_cycle(4'b0000, 1'b0, 1'b0, rnd());
    for (int i = 0; i < 3; i++) drive_cycle(4'b0010, 1'b1, 1'b1, rnd());
    for (int i = 0; i < 5; i++) drive_cycle(4'b0010, 1'b0, 1'b1, rnd());
    for (int i = 0; i < 10; i++) drive_cycle(4'b0010, 1'b1, 1'b1, rnd());

    // Async reset mid-burst (channel 1 granted), then channel 0 after release.
    drive_cycle(4'b0001, 1'b1, 1'b0, rnd());
    for (int i = 0; i < 3; i++) drive_cycle(4'b0001, 1'b1, 1'b1, rnd());

    // Channel 3 at the limit: wraps to 0 when 0 requests, else re-grants itself.
    drive_cycle(4'b0000, 1'b0, 1'b0, rnd());
    drive_cycle(4'b1000, 1'b1, 1'b1, rnd());
    for (int i = 0; i < 10; i++) drive_cycle(4'b1001, 1'b1, 1'b1, rnd());
    drive_cycle(4'b0000, 1'b0, 1'b0, rnd());
    for (int i = 0; i < 20; i++) drive_cycle(4'b1000, 1'b1, 1'b1, rnd());
    drive_cycle(4'b0000, 1'b1, 1'b1, rnd());
    drive_cycle(4'b0000, 1'b1, 1'b1, rnd());

    // Random traffic with slowly changing requests and occasional resets.
    rq = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rq = 4'($urandom_range(15));
      drive_cycle(rq, 1'($urandom_range(3) != 0), 1'($urandom_range(299) != 0), rnd());
    end

    repeat (3) @(negedge clk_in);
    #5;
    chk("scoreboard_drained", cyc, 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_4ch.md
Name: rr_mux_arbiter_4ch

Overview:
Round-robin arbiter and sequencer for the shared 4:1 selection datapath. Four requesters each present a WIDTH-bit word. The block grants one requester at a time, drives the mux select, and forwards the selected word downstream with a valid/ready handshake. A per-grant burst limit (MAX_HOLD) forces rotation so no requester can starve the others.

Parameters:
WIDTH, 8, data width per requester channel
MAX_HOLD, 8, maximum transfers per grant before forced rotation; legal range 1..255

Ports:
clk_in  input  1  single clock; all state updates on rising edge
rst_n_in  input  1  asynchronous, active-low reset
req_in  input  4  request per channel; bit i = requester i
data_in  input  4*WIDTH  channel i word on bits [i*WIDTH +: WIDTH]
ready_in  input  1  downstream accepts data_out this cycle
gnt_out  output  4  registered one-hot grant; all zero when idle
sel_out  output  2  registered index of the granted channel (mux select)
valid_out  output  1  data_out valid: asserted iff the FSM is in GRANT and req_in[sel_out]=1 (combinational)
data_out  output  WIDTH  data_in slice selected by sel_out (combinational mux)
busy_out  output  1  high while the FSM is in GRANT

Behaviour:
- Reset (async assert, any time including mid-burst):
  - state=IDLE, gnt_out=0, sel_out=0, busy_out=0, valid_out=0.
  - Rotation pointer ptr=0; transfer counter cnt=0.
  - Deassertion is sampled on clk_in; the first edge after release behaves as IDLE.
- Winner selection, rr(ptr, req):
  - Search req from index ptr upward, modulo 4. The first set bit wins.
  - With ptr=0 the order is 0,1,2,3; with ptr=2 it is 2,3,0,1.
- Transfer: a transfer occurs on a rising edge where valid_out=1 and ready_in=1.
- FSM state IDLE:
  - If req_in!=0 at an edge: sel_out<=rr(ptr, req_in), gnt_out<=one-hot(sel_out), cnt<=0, state<=GRANT.
  - Grant latency: a request sampled at edge N produces gnt_out at edge N (visible in the cycle after N). The first transfer can occur at edge N+1.
  - If req_in=0, the FSM stays in IDLE with gnt_out=0.
- FSM state GRANT:
  - On a transfer with cnt<MAX_HOLD-1: cnt<=cnt+1 and the grant is held.
  - ready_in=0 stalls the burst: cnt frozen, grant held, data_out keeps tracking data_in of sel_out.
  - Release occurs at an edge where either:
    - req_in[sel_out]=0 (requester dropped; no transfer in that cycle), or
    - a transfer occurs with cnt=MAX_HOLD-1 (burst limit reached).
- On release:
  - ptr<=sel_out+1 (mod 4).
  - If req_in evaluated with the current requester masked when it dropped is non-zero: sel_out/gnt_out <= rr(sel_out+1, that vector), cnt<=0, stay in GRANT. There is no idle bubble between grants.
  - A lone requester hitting the burst limit is re-granted to itself: gnt_out unchanged, cnt reset to 0.
  - If no request remains: gnt_out<=0, state<=IDLE.
- Request changes on non-granted channels during a burst affect only the next arbitration.
- Requests are level-sensitive; a requester must hold req_in until granted.
- cnt is 8 bits wide. MAX_HOLD=1 rotates after every transfer.
- data_out and valid_out are combinational from registered sel/state; no other output is combinational.

Test Plan:
1. Reset while gnt_out=0010 mid-burst (cnt=3) -> gnt_out=0, busy_out=0, sel_out=0 immediately; after release with req_in=0001, gnt_out=0001 one edge later.
2. req_in=0100, data_in slice2=8'hA5, ready_in=1 -> gnt_out=0100, sel_out=2 one cycle after the request; valid_out=1, data_out=8'hA5; 8 transfers then re-grant to 2 with cnt=0.
3. req_in=1111 held, ready_in=1, MAX_HOLD=8 -> grants 0,1,2,3,0 in sequence, each exactly 8 transfers; no cycle with gnt_out=0.
4. req_in=0011, channel 0 granted; drop req_in[0] after 3 transfers -> next edge gnt_out=0010 with no idle cycle; ptr=1.
5. Granted channel 1 with ready_in=0 for 5 cycles mid-burst -> cnt frozen, gnt_out held at 0010; burst completes 8 total transfers after ready_in returns.
6. Channel 3 granted and hits the limit with req_in=1001 -> next grant to 0 (wrap-around); with req_in=1000 only, re-grant to 3.
